// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: a small in-order FIFO of
// stores drained one per cycle, with a word-granular load-collision check.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [31:0] req_pc,
  output logic        stall,
  input  logic        drain_en,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        DMWE,
  output logic [2:0]  DMOP,
  output logic [31:0] Address,
  output logic [31:0] Input,
  output logic [31:0] PC,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic   full, push, pop;
  entry_t head_e;

  // Full is judged on the count before the edge, so a same-cycle pop never
  // frees a slot for the request presented alongside it.
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign stall = req_valid && full;
  assign push  = req_valid && !full;
  assign pop   = !empty && drain_en;

  assign head_e  = empty ? '0 : mem_q[head_q];
  assign DMWE    = pop;
  assign DMOP    = head_e.op;
  assign Address = head_e.addr;
  assign Input   = head_e.data;
  assign PC      = head_e.pc;

  // Only the word index takes part in the collision check.
  logic unused_ld_bits;
  assign unused_ld_bits = ^{ld_addr[31:15], ld_addr[1:0]};

  // An entry is live when its distance from head is below count; the head being
  // drained this cycle is still live, the incoming request is not yet.
  always_comb begin : hazard_check
    logic [AW-1:0] off;
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head_q;
      if (ld_valid && ({1'b0, off} < count_q) &&
          (mem_q[i].addr[14:2] == ld_addr[14:2]))
        ld_hazard = 1'b1;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = '{op: req_op, addr: req_addr, data: req_data, pc: req_pc};
      tail_d        = tail_q + 1'b1;
    end
    if (pop)
      head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the entry storage is cleared on reset too, so a discarded store leaves no trace.
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule
